// File: rtl/tile_load_sequencer.sv
// rtl/tile_load_sequencer.sv - sequences one tile load from A/W BRAMs into per-row/per-column buffer RAMs
module tile_load_sequencer #(
    parameter int ARRAY_N    = 8,
    parameter int ARRAY_M    = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int K_WIDTH    = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [31:0]                a_bram_base,
    input  logic [31:0]                w_bram_base,
    input  logic [ADDR_WIDTH-1:0]      buf_base,
    input  logic [$clog2(ARRAY_N):0]   a_num_rows,
    input  logic [$clog2(ARRAY_M):0]   w_num_cols,
    input  logic [K_WIDTH-1:0]         k_len,
    output logic [31:0]                addr_a_bram,
    output logic                       enable_a_bram,
    output logic [31:0]                addr_w_bram,
    output logic                       enable_w_bram,
    output logic [ADDR_WIDTH-1:0]      a_ram_w_addr,
    output logic [ARRAY_N-1:0]         a_ram_w_en,
    output logic [ADDR_WIDTH-1:0]      w_ram_w_addr,
    output logic [ARRAY_M-1:0]         w_ram_w_en,
    output logic                       busy,
    output logic                       done
);

    localparam int RW = $clog2(ARRAY_N) + 1;
    localparam int CW = $clog2(ARRAY_M) + 1;
    localparam int IW = (RW > CW) ? RW : CW;
    localparam int PW = IW + K_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_W,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [K_WIDTH-1:0]    kcnt, kcnt_nxt;
    logic [31:0]           cfg_a_base, cfg_w_base;
    logic [ADDR_WIDTH-1:0] cfg_buf;
    logic [IW-1:0]         cfg_rows, cfg_cols;
    logic [K_WIDTH-1:0]    cfg_k;

    logic [IW-1:0]         rows_clamp, cols_clamp;
    logic                  accept;
    logic                  last_k;
    logic [PW-1:0]         row_off;
    logic [31:0]           word_addr;

    assign rows_clamp = (a_num_rows > RW'(ARRAY_N)) ? IW'(ARRAY_N) : IW'(a_num_rows);
    assign cols_clamp = (w_num_cols > CW'(ARRAY_M)) ? IW'(ARRAY_M) : IW'(w_num_cols);
    assign accept     = (state == S_IDLE) && start && !abort;
    assign last_k     = (kcnt == cfg_k - K_WIDTH'(1));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        kcnt_nxt  = kcnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    idx_nxt  = '0;
                    kcnt_nxt = '0;
                    if (rows_clamp != '0 && k_len != '0)
                        state_nxt = S_LOAD_A;
                    else if (cols_clamp != '0 && k_len != '0)
                        state_nxt = S_LOAD_W;
                    else
                        state_nxt = S_DRAIN;
                end
            end
            S_LOAD_A: begin
                if (last_k) begin
                    kcnt_nxt = '0;
                    if (idx == cfg_rows - IW'(1)) begin
                        idx_nxt   = '0;
                        state_nxt = (cfg_cols != '0) ? S_LOAD_W : S_DRAIN;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end else begin
                    kcnt_nxt = kcnt + K_WIDTH'(1);
                end
            end
            S_LOAD_W: begin
                if (last_k) begin
                    kcnt_nxt = '0;
                    if (idx == cfg_cols - IW'(1)) begin
                        idx_nxt   = '0;
                        state_nxt = S_DRAIN;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end else begin
                    kcnt_nxt = kcnt + K_WIDTH'(1);
                end
            end
            S_DRAIN:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            idx_nxt   = '0;
            kcnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            kcnt       <= '0;
            cfg_a_base <= '0;
            cfg_w_base <= '0;
            cfg_buf    <= '0;
            cfg_rows   <= '0;
            cfg_cols   <= '0;
            cfg_k      <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            kcnt  <= kcnt_nxt;
            if (accept) begin
                cfg_a_base <= a_bram_base;
                cfg_w_base <= w_bram_base;
                cfg_buf    <= buf_base;
                cfg_rows   <= rows_clamp;
                cfg_cols   <= cols_clamp;
                cfg_k      <= k_len;
            end
        end
    end

    // One shared row/column counter drives both phases, so one address datapath suffices.
    assign row_off   = PW'(idx) * PW'(cfg_k);
    assign word_addr = ((state == S_LOAD_W) ? cfg_w_base : cfg_a_base) + 32'(row_off) + 32'(kcnt);

    assign enable_a_bram = (state == S_LOAD_A);
    assign enable_w_bram = (state == S_LOAD_W);
    assign addr_a_bram   = enable_a_bram ? (word_addr << 2) : 32'd0;
    assign addr_w_bram   = enable_w_bram ? (word_addr << 2) : 32'd0;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

    // Writes trail reads by one cycle to match BRAM latency; abort drops the in-flight one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_ram_w_en   <= '0;
            a_ram_w_addr <= '0;
            w_ram_w_en   <= '0;
            w_ram_w_addr <= '0;
        end else begin
            if (state == S_LOAD_A && !abort) begin
                a_ram_w_en   <= ARRAY_N'(1) << idx;
                a_ram_w_addr <= cfg_buf + ADDR_WIDTH'(kcnt);
            end else begin
                a_ram_w_en   <= '0;
                a_ram_w_addr <= '0;
            end
            if (state == S_LOAD_W && !abort) begin
                w_ram_w_en   <= ARRAY_M'(1) << idx;
                w_ram_w_addr <= cfg_buf + ADDR_WIDTH'(kcnt);
            end else begin
                w_ram_w_en   <= '0;
                w_ram_w_addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tile_load_sequencer.sv
// tb/tb_tile_load_sequencer.sv - scoreboard bench for tile_load_sequencer
module tb_tile_load_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] a_bram_base = '0;
    logic [31:0] w_bram_base = '0;
    logic [9:0]  buf_base = '0;
    logic [3:0]  a_num_rows = '0;
    logic [3:0]  w_num_cols = '0;
    logic [5:0]  k_len = '0;
    logic [31:0] addr_a_bram, addr_w_bram;
    logic        enable_a_bram, enable_w_bram;
    logic [9:0]  a_ram_w_addr, w_ram_w_addr;
    logic [7:0]  a_ram_w_en, w_ram_w_en;
    logic        busy, done;

    tile_load_sequencer #(.ARRAY_N(8), .ARRAY_M(8), .ADDR_WIDTH(10), .K_WIDTH(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .a_bram_base(a_bram_base), .w_bram_base(w_bram_base), .buf_base(buf_base),
        .a_num_rows(a_num_rows), .w_num_cols(w_num_cols), .k_len(k_len),
        .addr_a_bram(addr_a_bram), .enable_a_bram(enable_a_bram),
        .addr_w_bram(addr_w_bram), .enable_w_bram(enable_w_bram),
        .a_ram_w_addr(a_ram_w_addr), .a_ram_w_en(a_ram_w_en),
        .w_ram_w_addr(w_ram_w_addr), .w_ram_w_en(w_ram_w_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] addr; } rd_t;
    typedef struct { int cyc; logic [7:0] en; logic [9:0] addr; } wr_t;

    rd_t qa_rd[$], qw_rd[$];
    wr_t qa_wr[$], qw_wr[$];
    int  compared = 0;
    int  mismatched = 0;

    // Scoreboard: every observed read/write must match the oldest expectation, cycle included.
    always @(negedge clk) begin
        rd_t er;
        wr_t ew;
        if (reset_n) begin
            if (enable_a_bram) begin
                compared++;
                if (qa_rd.size() == 0) begin
                    mismatched++;
                    $display("FAIL a_read unexpected cyc=%0d addr=%h", cyc, addr_a_bram);
                end else begin
                    er = qa_rd.pop_front();
                    if (er.cyc !== cyc || er.addr !== addr_a_bram) begin
                        mismatched++;
                        $display("FAIL a_read got cyc=%0d addr=%h want cyc=%0d addr=%h", cyc, addr_a_bram, er.cyc, er.addr);
                    end
                end
            end
            if (enable_w_bram) begin
                compared++;
                if (qw_rd.size() == 0) begin
                    mismatched++;
                    $display("FAIL w_read unexpected cyc=%0d addr=%h", cyc, addr_w_bram);
                end else begin
                    er = qw_rd.pop_front();
                    if (er.cyc !== cyc || er.addr !== addr_w_bram) begin
                        mismatched++;
                        $display("FAIL w_read got cyc=%0d addr=%h want cyc=%0d addr=%h", cyc, addr_w_bram, er.cyc, er.addr);
                    end
                end
            end
            if (a_ram_w_en != '0) begin
                compared++;
                if (qa_wr.size() == 0) begin
                    mismatched++;
                    $display("FAIL a_write unexpected cyc=%0d en=%h addr=%h", cyc, a_ram_w_en, a_ram_w_addr);
                end else begin
                    ew = qa_wr.pop_front();
                    if (ew.cyc !== cyc || ew.en !== a_ram_w_en || ew.addr !== a_ram_w_addr) begin
                        mismatched++;
                        $display("FAIL a_write got cyc=%0d en=%h addr=%h want cyc=%0d en=%h addr=%h",
                                 cyc, a_ram_w_en, a_ram_w_addr, ew.cyc, ew.en, ew.addr);
                    end
                end
            end
            if (w_ram_w_en != '0) begin
                compared++;
                if (qw_wr.size() == 0) begin
                    mismatched++;
                    $display("FAIL w_write unexpected cyc=%0d en=%h addr=%h", cyc, w_ram_w_en, w_ram_w_addr);
                end else begin
                    ew = qw_wr.pop_front();
                    if (ew.cyc !== cyc || ew.en !== w_ram_w_en || ew.addr !== w_ram_w_addr) begin
                        mismatched++;
                        $display("FAIL w_write got cyc=%0d en=%h addr=%h want cyc=%0d en=%h addr=%h",
                                 cyc, w_ram_w_en, w_ram_w_addr, ew.cyc, ew.en, ew.addr);
                    end
                end
            end
        end
    end

    // Reference model: expected reads/writes for one load, truncated after cycle lim.
    task automatic push_load(input int s, input int lim, input logic [31:0] ab, input logic [31:0] wb,
                             input logic [9:0] bb, input int rows, input int cols, input int k);
        int n = 0;
        int rc = (rows > 8) ? 8 : rows;
        int cc = (cols > 8) ? 8 : cols;
        logic [31:0] w;
        logic [7:0]  one_hot;
        for (int r = 0; r < rc; r++) begin
            for (int j = 0; j < k; j++) begin
                w = ab + 32'(r * k + j);
                one_hot = 8'(1 << r);
                if (s + n <= lim) qa_rd.push_back(rd_t'{cyc: s + n, addr: w << 2});
                if (s + n + 1 <= lim) qa_wr.push_back(wr_t'{cyc: s + n + 1, en: one_hot, addr: 10'(bb + 10'(j))});
                n++;
            end
        end
        for (int c = 0; c < cc; c++) begin
            for (int j = 0; j < k; j++) begin
                w = wb + 32'(c * k + j);
                one_hot = 8'(1 << c);
                if (s + n <= lim) qw_rd.push_back(rd_t'{cyc: s + n, addr: w << 2});
                if (s + n + 1 <= lim) qw_wr.push_back(wr_t'{cyc: s + n + 1, en: one_hot, addr: 10'(bb + 10'(j))});
                n++;
            end
        end
    endtask

    task automatic start_load(input logic [31:0] ab, input logic [31:0] wb, input logic [9:0] bb,
                              input int rows, input int cols, input int k, input int lim_rel, output int s);
        @(negedge clk);
        a_bram_base = ab; w_bram_base = wb; buf_base = bb;
        a_num_rows = 4'(rows); w_num_cols = 4'(cols); k_len = 6'(k);
        start = 1'b1;
        s = cyc + 1;
        push_load(s, s + lim_rel, ab, wb, bb, rows, cols, k);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            @(negedge clk);
            if (done) at = cyc;
        end
    endtask

    task automatic check_queues_empty(input string name);
        compared++;
        if (qa_rd.size() + qw_rd.size() + qa_wr.size() + qw_wr.size() != 0) begin
            mismatched++;
            $display("FAIL %s leftover expectations got %0d/%0d/%0d/%0d want 0", name,
                     qa_rd.size(), qa_wr.size(), qw_rd.size(), qw_wr.size());
        end
        qa_rd.delete(); qw_rd.delete(); qa_wr.delete(); qw_wr.delete();
    endtask

    task automatic test_reset();
        int s;
        repeat (2) @(negedge clk);
        compared++;
        if ({addr_a_bram, enable_a_bram, addr_w_bram, enable_w_bram, a_ram_w_addr, a_ram_w_en,
             w_ram_w_addr, w_ram_w_en, busy, done} !== '0) begin
            mismatched++;
            $display("FAIL reset_state outputs not all zero, busy=%b done=%b en_a=%b", busy, done, enable_a_bram);
        end
        reset_n = 1'b1;
        start_load(32'h10, 32'h40, 10'd5, 2, 2, 3, 2, s);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        compared++;
        if ({addr_a_bram, enable_a_bram, addr_w_bram, enable_w_bram, a_ram_w_addr, a_ram_w_en,
             w_ram_w_addr, w_ram_w_en, busy, done} !== '0) begin
            mismatched++;
            $display("FAIL async_reset outputs not zero mid-load, busy=%b en_a=%b a_w_en=%h", busy, enable_a_bram, a_ram_w_en);
        end
        check_queues_empty("reset_mid_load");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int s, at;
        start_load(32'h10, 32'h40, 10'd5, 2, 2, 3, 1000, s);
        wait_done(60, at);
        compared++;
        if (at !== s + 13) begin
            mismatched++;
            $display("FAIL basic_done got cyc=%0d want %0d", at, s + 13);
        end
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_busy_at_done got %b want 1", busy);
        end
        @(negedge clk);
        compared++;
        if ({done, busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL basic_after_done got done=%b busy=%b want 0 0", done, busy);
        end
        check_queues_empty("basic");
    endtask

    task automatic test_skip_a();
        int s, at;
        start_load(32'h77, 32'h200, 10'h3FF, 0, 3, 1, 1000, s);
        wait_done(30, at);
        compared++;
        if (at !== s + 4) begin
            mismatched++;
            $display("FAIL skip_a_done got cyc=%0d want %0d", at, s + 4);
        end
        @(negedge clk);
        check_queues_empty("skip_a");
    endtask

    task automatic test_k_zero();
        int s, at;
        start_load(32'h100, 32'h300, 10'd9, 3, 2, 0, 1000, s);
        wait_done(30, at);
        compared++;
        if (at !== s + 1) begin
            mismatched++;
            $display("FAIL k_zero_done got cyc=%0d want %0d", at, s + 1);
        end
        @(negedge clk);
        check_queues_empty("k_zero");
    endtask

    task automatic test_clamp();
        int s, at;
        start_load(32'hFFFF_FFFC, 32'h0, 10'h3FF, 15, 0, 1, 1000, s);
        wait_done(40, at);
        compared++;
        if (at !== s + 9) begin
            mismatched++;
            $display("FAIL clamp_done got cyc=%0d want %0d", at, s + 9);
        end
        @(negedge clk);
        check_queues_empty("clamp");
    endtask

    task automatic test_start_while_busy();
        int s, at, extra;
        start_load(32'h20, 32'h30, 10'h3FF, 1, 1, 2, 1000, s);
        @(negedge clk);
        a_num_rows = 4'd4; k_len = 6'd5; a_bram_base = 32'h999;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(40, at);
        compared++;
        if (at !== s + 5) begin
            mismatched++;
            $display("FAIL busy_start_done got cyc=%0d want %0d", at, s + 5);
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        compared++;
        if (extra !== 0) begin
            mismatched++;
            $display("FAIL busy_start_restart got %0d busy cycles want 0", extra);
        end
        check_queues_empty("start_while_busy");
    endtask

    task automatic test_abort();
        int s, seen;
        start_load(32'h50, 32'h60, 10'd2, 1, 2, 2, 3, s);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_idle got busy=%b want 0", busy);
        end
        compared++;
        if (w_ram_w_en !== 8'h00) begin
            mismatched++;
            $display("FAIL abort_write_suppressed got w_en=%h want 00", w_ram_w_en);
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL abort_no_done got %0d done pulses want 0", seen);
        end
        check_queues_empty("abort");
    endtask

    task automatic test_abort_start_idle();
        int seen;
        @(negedge clk);
        a_num_rows = 4'd1; w_num_cols = 4'd1; k_len = 6'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_start_idle got busy=%b want 0", busy);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL abort_start_later got %0d busy cycles want 0", seen);
        end
        check_queues_empty("abort_start_idle");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip_a();
        test_k_zero();
        test_clamp();
        test_start_while_busy();
        test_abort();
        test_abort_start_idle();
        test_basic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
